// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchronizer, per-bit stability counter, and
// registered one-cycle rise/fall strobes aligned with the debounced level.
module sw_debounce #(
  parameter int WIDTH        = 3,
  parameter int STABLE_COUNT = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam int            CW   = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] flip;

  // A bit flips on the cycle its mismatch run reaches STABLE_COUNT samples.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (q2[i] != sw_db[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1         <= '0;
      q2         <= '0;
      sw_db      <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      q1         <= sw_in;
      q2         <= q1;
      sw_db      <= sw_db ^ flip;
      sw_rise    <= flip & ~sw_db;
      sw_fall    <= flip & sw_db;
      any_change <= |flip;
      for (int i = 0; i < WIDTH; i++) begin
        if ((q2[i] == sw_db[i]) || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two builds (STABLE_COUNT 4 and 1) driven by the same
// switch stimulus, each compared every cycle against a sample-window model.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw_in = 3'b000;

  logic [2:0] db4, rise4, fall4;
  logic       any4;
  logic [2:0] db1, rise1, fall1;
  logic       any1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(3), .STABLE_COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sw_db(db4), .sw_rise(rise4), .sw_fall(fall4), .any_change(any4)
  );

  sw_debounce #(.WIDTH(3), .STABLE_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sw_db(db1), .sw_rise(rise1), .sw_fall(fall1), .any_change(any1)
  );

  typedef struct packed {
    logic [2:0] db;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       any;
  } exp_t;

  exp_t       sb4[$];
  exp_t       sb1[$];
  logic [2:0] hist4[$];
  logic [2:0] hist1[$];
  logic [2:0] mdb4, mdb1;

  // h[0] is the raw sample at the previous edge; the synchronizer adds one
  // more edge, so h[1..s] are the last s values presented to the counter.
  function automatic exp_t next_exp(input int s, input logic [2:0] h[$],
                                    input logic [2:0] db);
    exp_t       e;
    logic [2:0] flip;
    flip = '0;
    for (int i = 0; i < 3; i++) begin
      logic all_diff;
      all_diff = 1'b1;
      for (int t = 1; t <= s; t++) begin
        if (h[t][i] == db[i]) all_diff = 1'b0;
      end
      flip[i] = all_diff;
    end
    e.db   = db ^ flip;
    e.rise = flip & ~db;
    e.fall = flip & db;
    e.any  = |flip;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      hist4 = {};
      hist1 = {};
      for (int k = 0; k < 6; k++) hist4.push_back(3'b000);
      for (int k = 0; k < 3; k++) hist1.push_back(3'b000);
      mdb4 = '0;
      mdb1 = '0;
      sb4.push_back('0);
      sb1.push_back('0);
    end else begin
      e = next_exp(4, hist4, mdb4);
      mdb4 = e.db;
      sb4.push_back(e);
      e = next_exp(1, hist1, mdb1);
      mdb1 = e.db;
      sb1.push_back(e);
      hist4.push_front(sw_in);
      void'(hist4.pop_back());
      hist1.push_front(sw_in);
      void'(hist1.pop_back());
    end
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual db/rise/fall/any=%b required=%b", name, $time, act, req);
    end
  endtask

  // Reset is asynchronous: while it is high every output must already be 0.
  always @(negedge clk) begin
    exp_t e;
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      if (rst) e = '0;
      check("sc4", {db4, rise4, fall4, any4}, e);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      if (rst) e = '0;
      check("sc1", {db1, rise1, fall1, any1}, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    int first;
    rst   = 1'b1;
    sw_in = 3'b111;
    tick(3);
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (db4 == 3'b111 && first == 0) first = k;
    end
    #2;
    check("rst_release_edge", 10'(first), 10'd6);

    sw_in = 3'b000; tick(10);
    sw_in = 3'b010; tick(10);
    sw_in = 3'b000; tick(10);

    repeat (3) begin
      sw_in = 3'b001; tick(3);
      sw_in = 3'b000; tick(1);
      sw_in = 3'b001; tick(2);
      sw_in = 3'b000; tick(1);
    end
    sw_in = 3'b001; tick(10);
    sw_in = 3'b000; tick(10);

    sw_in = 3'b001; tick(10);
    sw_in = 3'b110; tick(10);
    sw_in = 3'b000; tick(10);

    sw_in = 3'b100; tick(3);
    rst   = 1'b1;   tick(2);
    rst   = 1'b0;   tick(10);
    sw_in = 3'b000; tick(10);

    sw_in = 3'b001; tick(2);
    sw_in = 3'b000; tick(6);

    for (int n = 0; n < 150; n++) begin
      sw_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
      tick($urandom_range(1, 7));
    end
    sw_in = 3'b000;
    tick(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
